uart_rx_cfg: RTL and testbench

//  Parametrised UART receiver; next generation of the single-format 8N1 receiver. Adds

---
 rtl/uart_rx_cfg_pkg.sv | 26 ++
 rtl/uart_rx_sampler.sv | 46 ++++
 rtl/uart_rx_cfg.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_cfg_pkg.sv
// Shared types for the configurable UART receiver.
// Parity encoding, FSM state encoding, width limit and vote helper.
package uart_rx_cfg_pkg;

    localparam int UART_MAX_DATA_BITS = 9;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD,
        PAR_RSVD
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning for the UART receiver: synchroniser, falling-edge
// detect and 3-sample majority vote.
// Ports: clk/reset, in (async line), take_a/take_b (capture strobes for the
// first two mid-bit samples), fall (synchronised high->low), vote (majority
// of the two captured samples and the current synchronised line).
module uart_rx_sampler
    import uart_rx_cfg_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    input  logic take_a,
    input  logic take_b,
    output logic fall,
    output logic vote
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   line;
    logic                   prev;
    logic                   sa;
    logic                   sb;

    assign line = sync[SYNC_STAGES-1];

    // Everything resets to the idle-high level so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '1;
            prev <= 1'b1;
            sa   <= 1'b1;
            sb   <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], in};
            prev <= line;
            if (take_a) sa <= line;
            if (take_b) sb <= line;
        end
    end

    assign fall = prev & ~line;
    assign vote = maj3(sa, sb, line);

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver with runtime parity/stop selection, false-start
// rejection, break detection and a valid/ready holding register.
// Ports: clk, reset (sync, active high), rx_enabled, in (serial line),
// s_tick (oversample strobe), parity_mode, two_stop, clr_status;
// out/out_valid/out_ready handshake, frame_err/parity_err/break_det
// (qualified by out_valid), overrun (sticky), busy.
module uart_rx_cfg
    import uart_rx_cfg_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_enabled,
    input  logic                 in,
    input  logic                 s_tick,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic                 clr_status,
    output logic [DATA_BITS-1:0] out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW  = $clog2(OVERSAMPLE);
    localparam int MID = OVERSAMPLE / 2;
    localparam int BW  = $clog2(UART_MAX_DATA_BITS + 1);

    localparam logic [CW-1:0] C_A   = CW'(MID - 1);
    localparam logic [CW-1:0] C_B   = CW'(MID);
    localparam logic [CW-1:0] C_D   = CW'(MID + 1);
    localparam logic [CW-1:0] C_END = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] C_LAST = BW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'(IDLE);
    localparam logic [2:0] S_START  = 3'(START);
    localparam logic [2:0] S_DATA   = 3'(DATA);
    localparam logic [2:0] S_PARITY = 3'(PARITY);
    localparam logic [2:0] S_STOP   = 3'(STOP);

    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] sr;
    logic [1:0]           par_q;
    logic                 two_q;
    logic                 zero_q;
    logic                 fe_q;
    logic                 pe_q;
    logic                 bk_q;
    logic                 done;

    logic fall;
    logic vote;
    logic active;
    logic take_a;
    logic take_b;
    logic tick_mid;
    logic tick_end;
    logic par_on;
    logic exp_par;

    assign active   = (state != S_IDLE);
    assign take_a   = active && s_tick && (cnt == C_A);
    assign take_b   = active && s_tick && (cnt == C_B);
    assign tick_mid = s_tick && (cnt == C_D);
    assign tick_end = s_tick && (cnt == C_END);
    assign par_on   = (par_q == 2'(PAR_EVEN)) || (par_q == 2'(PAR_ODD));
    assign exp_par  = (^sr) ^ (par_q == 2'(PAR_ODD));
    assign busy     = active;

    uart_rx_sampler #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sampler (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .take_a(take_a),
        .take_b(take_b),
        .fall  (fall),
        .vote  (vote)
    );

    // Decisions are taken at the third mid-bit tick, once the vote is complete.
    // A break leaves the line low on return to IDLE; a new frame needs a
    // fresh falling edge, so the receiver waits for the line to rise first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            sr       <= '0;
            par_q    <= 2'(PAR_NONE);
            two_q    <= 1'b0;
            zero_q   <= 1'b0;
            fe_q     <= 1'b0;
            pe_q     <= 1'b0;
            bk_q     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (active && s_tick)
                cnt <= tick_end ? '0 : cnt + 1'b1;
            if (active && !rx_enabled) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (rx_enabled && fall) begin
                            state  <= S_START;
                            cnt    <= '0;
                            par_q  <= parity_mode;
                            two_q  <= two_stop;
                            zero_q <= 1'b1;
                            fe_q   <= 1'b0;
                            pe_q   <= 1'b0;
                            bk_q   <= 1'b0;
                        end
                    end
                    S_START: begin
                        if (tick_mid && vote) begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end else if (tick_end) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end
                    end
                    S_DATA: begin
                        if (tick_mid) begin
                            sr <= {vote, sr[DATA_BITS-1:1]};
                            if (vote) zero_q <= 1'b0;
                        end
                        if (tick_end) begin
                            if (bit_idx == C_LAST) begin
                                state    <= par_on ? S_PARITY : S_STOP;
                                stop_idx <= 1'b0;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (tick_mid) begin
                            pe_q <= (vote != exp_par);
                            if (vote) zero_q <= 1'b0;
                        end
                        if (tick_end) begin
                            state    <= S_STOP;
                            stop_idx <= 1'b0;
                        end
                    end
                    S_STOP: begin
                        if (tick_mid) begin
                            fe_q <= fe_q | ~vote;
                            if (!stop_idx) bk_q <= zero_q & ~vote;
                            if (stop_idx || !two_q) begin
                                state <= S_IDLE;
                                cnt   <= '0;
                                done  <= 1'b1;
                            end
                        end else if (tick_end) begin
                            stop_idx <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Holding register: a completed frame loads only if the slot is free
    // or being drained this cycle; otherwise it is dropped and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            out        <= '0;
            out_valid  <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (done && (!out_valid || out_ready)) begin
                out        <= sr;
                out_valid  <= 1'b1;
                frame_err  <= fe_q;
                parity_err <= pe_q;
                break_det  <= bk_q;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (done && out_valid && !out_ready)
                overrun <= 1'b1;
            else if (clr_status)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: 8-bit and 7-bit instances,
// scoreboard queues checked on every output handshake.
module tb_uart_rx_cfg;

    typedef struct packed {
        logic [8:0] d;
        logic       fe;
        logic       pe;
        logic       bk;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_en = 1'b1;
    logic       s_tick = 1'b0;
    logic       ts = 1'b0;
    logic       clr = 1'b0;
    logic       ready = 1'b1;
    logic       l8 = 1'b1;
    logic       l7 = 1'b1;
    logic [1:0] pm8 = 2'b00;
    logic [1:0] pm7 = 2'b01;
    int         div = 0;

    logic [7:0] out8;
    logic       v8, fe8, pe8, bk8, ov8, busy8;
    logic [6:0] out7;
    logic       v7, fe7, pe7, bk7, ov7, busy7;

    exp_t q8[$];
    exp_t q7[$];
    int   checks = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // baud_gen divisor 5: one tick every 5 clk, 16 ticks per 80-clk bit
    always @(posedge clk) begin
        div    <= (div == 4) ? 0 : div + 1;
        s_tick <= (div == 4);
    end

    uart_rx_cfg #(.DATA_BITS(8)) u8 (
        .clk(clk), .reset(reset), .rx_enabled(rx_en), .in(l8),
        .s_tick(s_tick), .parity_mode(pm8), .two_stop(ts),
        .clr_status(clr), .out(out8), .out_valid(v8),
        .out_ready(ready), .frame_err(fe8), .parity_err(pe8),
        .break_det(bk8), .overrun(ov8), .busy(busy8)
    );

    uart_rx_cfg #(.DATA_BITS(7)) u7 (
        .clk(clk), .reset(reset), .rx_enabled(rx_en), .in(l7),
        .s_tick(s_tick), .parity_mode(pm7), .two_stop(1'b0),
        .clr_status(clr), .out(out7), .out_valid(v7),
        .out_ready(ready), .frame_err(fe7), .parity_err(pe7),
        .break_det(bk7), .overrun(ov7), .busy(busy7)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setl(input int which, input logic v);
        if (which == 7) l7 = v;
        else l8 = v;
    endtask

    task automatic push(input int which, input logic [8:0] d,
                        input logic fe, input logic pe, input logic bk);
        exp_t e;
        e = '{d: d, fe: fe, pe: pe, bk: bk};
        if (which == 7) q7.push_back(e);
        else q8.push_back(e);
    endtask

    // pm: 0 none, 1 even, 2 odd; g = data bit to glitch mid-sample (-1 none)
    task automatic send(input int which, input logic [8:0] d, input int n,
                        input int pm, input bit flip, input int nstop,
                        input int g);
        logic p;
        p = (pm == 2);
        for (int i = 0; i < n; i++) p ^= d[i];
        setl(which, 1'b0);
        tk(80);
        for (int i = 0; i < n; i++) begin
            setl(which, d[i]);
            if (i == g) begin
                tk(44);
                setl(which, ~d[i]);
                tk(4);
                setl(which, d[i]);
                tk(32);
            end else begin
                tk(80);
            end
        end
        if (pm == 1 || pm == 2) begin
            setl(which, p ^ flip);
            tk(80);
        end
        for (int s = 0; s < nstop; s++) begin
            setl(which, 1'b1);
            tk(80);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && v8 && ready) begin
            chk("u8_word_expected", 32'(q8.size() > 0), 1);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                chk("u8_out", 32'(out8), 32'(e.d[7:0]));
                chk("u8_frame_err", 32'(fe8), 32'(e.fe));
                chk("u8_parity_err", 32'(pe8), 32'(e.pe));
                chk("u8_break_det", 32'(bk8), 32'(e.bk));
            end
        end
        if (!reset && v7 && ready) begin
            chk("u7_word_expected", 32'(q7.size() > 0), 1);
            if (q7.size() > 0) begin
                e = q7.pop_front();
                chk("u7_out", 32'(out7), 32'(e.d[6:0]));
                chk("u7_frame_err", 32'(fe7), 32'(e.fe));
                chk("u7_parity_err", 32'(pe7), 32'(e.pe));
                chk("u7_break_det", 32'(bk7), 32'(e.bk));
            end
        end
    end

    initial begin
        // reset state
        tk(6);
        reset = 1'b0;
        tk(1);
        chk("rst_out", 32'(out8), 0);
        chk("rst_valid", 32'(v8), 0);
        chk("rst_flags", 32'({fe8, pe8, bk8}), 0);
        chk("rst_overrun", 32'(ov8), 0);
        chk("rst_busy", 32'(busy8), 0);
        tk(40);

        // 1: 8N1 back-to-back, then one two-stop frame
        push(8, 9'h0A5, 0, 0, 0); send(8, 9'h0A5, 8, 0, 0, 1, -1);
        push(8, 9'h05A, 0, 0, 0); send(8, 9'h05A, 8, 0, 0, 1, -1);
        push(8, 9'h0FF, 0, 0, 0); send(8, 9'h0FF, 8, 0, 0, 1, -1);
        push(8, 9'h000, 0, 0, 0); send(8, 9'h000, 8, 0, 0, 1, -1);
        push(8, 9'h078, 0, 0, 0); send(8, 9'h078, 8, 0, 0, 1, -1);
        ts = 1'b1;
        push(8, 9'h03C, 0, 0, 0); send(8, 9'h03C, 8, 0, 0, 2, -1);
        ts = 1'b0;
        tk(40);
        chk("t1_drained", 32'(q8.size()), 0);

        // 2: 7-bit even parity, good then flipped parity bit
        push(7, 9'h035, 0, 0, 0); send(7, 9'h035, 7, 1, 0, 1, -1);
        push(7, 9'h035, 0, 1, 0); send(7, 9'h035, 7, 1, 1, 1, -1);
        tk(40);
        chk("t2_drained", 32'(q7.size()), 0);

        // 3: 40-clk start pulse is a false start
        l8 = 1'b0;
        tk(40);
        l8 = 1'b1;
        tk(120);
        chk("t3_busy", 32'(busy8), 0);
        chk("t3_valid", 32'(v8), 0);
        push(8, 9'h012, 0, 0, 0); send(8, 9'h012, 8, 0, 0, 1, -1);
        tk(40);

        // 4: overrun with consumer stalled
        ready = 1'b0;
        push(8, 9'h034, 0, 0, 0); send(8, 9'h034, 8, 0, 0, 1, -1);
        send(8, 9'h056, 8, 0, 0, 1, -1);
        tk(2);
        chk("t4_valid", 32'(v8), 1);
        chk("t4_held", 32'(out8), 32'h34);
        chk("t4_overrun", 32'(ov8), 1);
        clr = 1'b1;
        tk(1);
        clr = 1'b0;
        chk("t4_ovr_clr", 32'(ov8), 0);
        ready = 1'b1;
        tk(3);
        chk("t4_drained", 32'(q8.size()), 0);
        chk("t4_valid_low", 32'(v8), 0);
        tk(40);

        // 5: break for two frame times, then a clean frame
        push(8, 9'h000, 1, 0, 1);
        l8 = 1'b0;
        tk(1600);
        l8 = 1'b1;
        tk(160);
        chk("t5_one_word", 32'(q8.size()), 0);
        push(8, 9'h0C3, 0, 0, 0); send(8, 9'h0C3, 8, 0, 0, 1, -1);
        tk(40);

        // 6a: rx_enabled dropped mid-data
        l8 = 1'b0; tk(80);
        l8 = 1'b1; tk(80);
        l8 = 1'b0; tk(80);
        l8 = 1'b1; tk(40);
        rx_en = 1'b0;
        tk(3);
        chk("t6_abort_busy", 32'(busy8), 0);
        chk("t6_abort_valid", 32'(v8), 0);
        tk(900);
        rx_en = 1'b1;
        tk(20);

        // 6b: reset mid-frame
        l8 = 1'b0; tk(80);
        l8 = 1'b1; tk(40);
        chk("t6_busy_pre", 32'(busy8), 1);
        reset = 1'b1;
        tk(1);
        reset = 1'b0;
        tk(1);
        chk("t6_rst_out", 32'(out8), 0);
        chk("t6_rst_valid", 32'(v8), 0);
        chk("t6_rst_flags", 32'({fe8, pe8, bk8, ov8}), 0);
        chk("t6_rst_busy", 32'(busy8), 0);
        tk(900);

        // 6c: clean frame with one glitched mid-bit sample on bit 3
        push(8, 9'h099, 0, 0, 0); send(8, 9'h099, 8, 0, 0, 1, 3);
        tk(60);

        chk("end_q8_empty", 32'(q8.size()), 0);
        chk("end_q7_empty", 32'(q7.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
